// File: rtl/regfile_mp_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : regfile_mp_scoreboard
// Purpose  : Multi-port integer register file for the pipelined RV32IM core.
//            - NUM_RD_PORTS combinational read ports, two write ports
//              (port 0 = ALU writeback, port 1 = long-latency writeback).
//            - Optional same-cycle write-to-read bypass.
//            - One busy bit per register, set at issue and cleared at
//              writeback, for the decode/hazard stall logic.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_mp_scoreboard #(
   parameter  int DATA_WIDTH   = 32,
   parameter  int NUM_REGS     = 32,
   parameter  int NUM_RD_PORTS = 2,
   parameter  int ZERO_REG     = 1,
   parameter  int BYPASS       = 1,
   localparam int AW           = $clog2(NUM_REGS)
) (
   input  logic                               i_clk,
   input  logic                               i_rst_n,
   input  logic                               i_we0,
   input  logic [AW-1:0]                      i_wr0_addr,
   input  logic [DATA_WIDTH-1:0]              i_wr0_data,
   input  logic                               i_we1,
   input  logic [AW-1:0]                      i_wr1_addr,
   input  logic [DATA_WIDTH-1:0]              i_wr1_data,
   input  logic [NUM_RD_PORTS*AW-1:0]         i_rs_addr,
   output logic [NUM_RD_PORTS*DATA_WIDTH-1:0] o_rs_data,
   output logic [NUM_RD_PORTS-1:0]            o_rs_busy,
   input  logic                               i_issue,
   input  logic [AW-1:0]                      i_issue_addr,
   output logic                               o_issue_waw,
   output logic [NUM_REGS-1:0]                o_busy_vec
);

   // Architectural state
   logic [DATA_WIDTH-1:0] regs [NUM_REGS];
   logic [NUM_REGS-1:0]   busy;

   // Per-register strobes decoded from the write and issue ports
   logic [NUM_REGS-1:0]   wr0_hit;
   logic [NUM_REGS-1:0]   wr1_hit;
   logic [NUM_REGS-1:0]   set_vec;
   logic [NUM_REGS-1:0]   busy_nxt;

   // Read-path temporaries
   logic [AW-1:0]         rd_addr;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  rd_busy;

   // Decode write/issue addresses into one-hot strobes; register 0 is
   // excluded when it is hardwired so it can never be written or marked busy.
   always_comb begin
      wr0_hit = '0;
      wr1_hit = '0;
      set_vec = '0;
      for (int r = 0; r < NUM_REGS; r++) begin
         wr0_hit[r] = i_we0   && (i_wr0_addr   == AW'(r));
         wr1_hit[r] = i_we1   && (i_wr1_addr   == AW'(r));
         set_vec[r] = i_issue && (i_issue_addr == AW'(r));
      end
      if (ZERO_REG != 0) begin
         wr0_hit[0] = 1'b0;
         wr1_hit[0] = 1'b0;
         set_vec[0] = 1'b0;
      end
   end

   // Next scoreboard value: writeback clears, issue sets, and a set wins
   // because the newly issued producer is still in flight.
   always_comb begin
      busy_nxt = (busy & ~(wr0_hit | wr1_hit)) | set_vec;
      if (ZERO_REG != 0) begin
         busy_nxt[0] = 1'b0;
      end
   end

   // Register array; port 1 overrides port 0 on an address collision.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int r = 0; r < NUM_REGS; r++) begin
            regs[r] <= '0;
         end
      end else begin
         for (int r = 0; r < NUM_REGS; r++) begin
            if (wr1_hit[r]) begin
               regs[r] <= i_wr1_data;
            end else if (wr0_hit[r]) begin
               regs[r] <= i_wr0_data;
            end
         end
      end
   end

   // Scoreboard busy bits; reset drops all pending producers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         busy <= '0;
      end else begin
         busy <= busy_nxt;
      end
   end

   // Combinational read ports with optional forwarding of this cycle's
   // writes; a forwarded register is no longer pending, so its busy flag is
   // masked. Outputs are held at zero while reset is asserted so that the
   // bypass path cannot leak write data during reset.
   always_comb begin
      o_rs_data = '0;
      o_rs_busy = '0;
      rd_addr   = '0;
      rd_data   = '0;
      rd_busy   = 1'b0;
      for (int k = 0; k < NUM_RD_PORTS; k++) begin
         rd_addr = i_rs_addr[k*AW +: AW];
         rd_data = regs[rd_addr];
         rd_busy = busy[rd_addr];
         if (BYPASS != 0) begin
            if (i_we1 && (i_wr1_addr == rd_addr)) begin
               rd_data = i_wr1_data;
               rd_busy = 1'b0;
            end else if (i_we0 && (i_wr0_addr == rd_addr)) begin
               rd_data = i_wr0_data;
               rd_busy = 1'b0;
            end
         end
         if ((ZERO_REG != 0) && (rd_addr == '0)) begin
            rd_data = '0;
            rd_busy = 1'b0;
         end
         if (!i_rst_n) begin
            rd_data = '0;
            rd_busy = 1'b0;
         end
         o_rs_data[k*DATA_WIDTH +: DATA_WIDTH] = rd_data;
         o_rs_busy[k]                          = rd_busy;
      end
   end

   // WAW flag is advisory and deliberately not masked by same-cycle writes.
   assign o_issue_waw = i_rst_n & i_issue & busy[i_issue_addr];
   assign o_busy_vec  = busy;

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_mp_scoreboard
// Purpose  : Self-checking bench for regfile_mp_scoreboard. Two instances
//            (bypass enabled / disabled) share stimulus and are compared
//            against a behavioural register/scoreboard model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_mp_scoreboard;

   localparam int DW = 32;
   localparam int NR = 32;
   localparam int AW = 5;
   localparam int NP = 2;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              we0, we1, issue;
   logic [AW-1:0]     wr0_addr, wr1_addr, issue_addr;
   logic [DW-1:0]     wr0_data, wr1_data;
   logic [NP*AW-1:0]  rs_addr;
   logic [NP*DW-1:0]  rs_data, rs_data_nb;
   logic [NP-1:0]     rs_busy, rs_busy_nb;
   logic              issue_waw, issue_waw_nb;
   logic [NR-1:0]     busy_vec, busy_vec_nb;

   int n_checks = 0;
   int n_errors = 0;

   // Behavioural model state
   logic [DW-1:0] mreg [NR];
   logic [NR-1:0] mbusy;

   always #5 clk = ~clk;

   regfile_mp_scoreboard #(
      .DATA_WIDTH(DW), .NUM_REGS(NR), .NUM_RD_PORTS(NP), .ZERO_REG(1), .BYPASS(1)
   ) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_we0(we0), .i_wr0_addr(wr0_addr), .i_wr0_data(wr0_data),
      .i_we1(we1), .i_wr1_addr(wr1_addr), .i_wr1_data(wr1_data),
      .i_rs_addr(rs_addr), .o_rs_data(rs_data), .o_rs_busy(rs_busy),
      .i_issue(issue), .i_issue_addr(issue_addr), .o_issue_waw(issue_waw),
      .o_busy_vec(busy_vec)
   );

   regfile_mp_scoreboard #(
      .DATA_WIDTH(DW), .NUM_REGS(NR), .NUM_RD_PORTS(NP), .ZERO_REG(1), .BYPASS(0)
   ) dut_nb (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_we0(we0), .i_wr0_addr(wr0_addr), .i_wr0_data(wr0_data),
      .i_we1(we1), .i_wr1_addr(wr1_addr), .i_wr1_data(wr1_data),
      .i_rs_addr(rs_addr), .o_rs_data(rs_data_nb), .o_rs_busy(rs_busy_nb),
      .i_issue(issue), .i_issue_addr(issue_addr), .o_issue_waw(issue_waw_nb),
      .o_busy_vec(busy_vec_nb)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int r = 0; r < NR; r++) mreg[r] = '0;
      mbusy = '0;
   endtask

   // Value a reader should see this cycle
   function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a, input bit byp);
      if (a == 0) return '0;
      if (byp && we1 && wr1_addr == a) return wr1_data;
      if (byp && we0 && wr0_addr == a) return wr0_data;
      return mreg[a];
   endfunction

   function automatic logic exp_busy(input logic [AW-1:0] a, input bit byp);
      if (byp && ((we0 && wr0_addr == a) || (we1 && wr1_addr == a))) return 1'b0;
      return mbusy[a];
   endfunction

   // Architectural effect of one clock edge
   task automatic model_clock();
      if (we0 && wr0_addr != 0) mreg[wr0_addr] = wr0_data;
      if (we1 && wr1_addr != 0) mreg[wr1_addr] = wr1_data;
      if (we0) mbusy[wr0_addr] = 1'b0;
      if (we1) mbusy[wr1_addr] = 1'b0;
      if (issue && issue_addr != 0) mbusy[issue_addr] = 1'b1;
   endtask

   task automatic set_idle();
      we0 = 0; we1 = 0; issue = 0;
      wr0_addr = '0; wr1_addr = '0; issue_addr = '0;
      wr0_data = '0; wr1_data = '0; rs_addr = '0;
   endtask

   // Called at a falling edge with inputs applied; checks combinational
   // outputs, clocks once, checks the scoreboard, returns at the next fall.
   task automatic run_cycle();
      logic [AW-1:0] a;
      #1;
      for (int k = 0; k < NP; k++) begin
         a = rs_addr[k*AW +: AW];
         check_val($sformatf("rd%0d_data", k), rs_data[k*DW +: DW], exp_data(a, 1'b1));
         check_val($sformatf("rd%0d_data_nb", k), rs_data_nb[k*DW +: DW], exp_data(a, 1'b0));
         check_val($sformatf("rd%0d_busy", k), {31'b0, rs_busy[k]}, {31'b0, exp_busy(a, 1'b1)});
         check_val($sformatf("rd%0d_busy_nb", k), {31'b0, rs_busy_nb[k]}, {31'b0, exp_busy(a, 1'b0)});
      end
      check_val("issue_waw", {31'b0, issue_waw}, {31'b0, issue & mbusy[issue_addr]});
      check_val("issue_waw_nb", {31'b0, issue_waw_nb}, {31'b0, issue & mbusy[issue_addr]});
      @(posedge clk);
      model_clock();
      #1;
      check_val("busy_vec", busy_vec, mbusy);
      check_val("busy_vec_nb", busy_vec_nb, mbusy);
      @(negedge clk);
   endtask

   task automatic random_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         we0        = 1'($urandom_range(0, 1));
         we1        = 1'($urandom_range(0, 1));
         issue      = 1'($urandom_range(0, 1));
         wr0_addr   = AW'($urandom_range(0, 7));
         wr1_addr   = AW'($urandom_range(0, 7));
         issue_addr = AW'($urandom_range(0, 7));
         if ($urandom_range(0, 9) == 0) issue_addr = AW'($urandom);
         wr0_data   = $urandom;
         wr1_data   = $urandom;
         for (int k = 0; k < NP; k++) rs_addr[k*AW +: AW] = AW'($urandom_range(0, 7));
         run_cycle();
      end
   endtask

   initial begin
      set_idle();
      model_reset();
      rst_n = 1'b0;
      #2;
      check_val("rst_busy_vec", busy_vec, '0);
      check_val("rst_rs_data", rs_data[31:0], '0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Zero register ignores writes and never reads nonzero
      set_idle();
      we0 = 1; wr0_addr = '0; wr0_data = 32'hDEADBEEF;
      #1;
      check_val("x0_wr_data", rs_data[31:0], 32'h0);
      check_val("x0_wr_busy", {31'b0, rs_busy[0]}, 32'h0);
      run_cycle();
      set_idle();
      run_cycle();
      check_val("x0_after", rs_data[31:0], 32'h0);

      // Dual write collision on x7: port 1 wins
      set_idle();
      we0 = 1; wr0_addr = 5'd7; wr0_data = 32'hAAAA;
      we1 = 1; wr1_addr = 5'd7; wr1_data = 32'h5555;
      rs_addr[AW +: AW] = 5'd7;
      #1;
      check_val("x7_bypass", rs_data[DW +: DW], 32'h5555);
      run_cycle();
      set_idle();
      rs_addr[AW +: AW] = 5'd7;
      #1;
      check_val("x7_after", rs_data[DW +: DW], 32'h5555);
      run_cycle();

      // Bypass vs no-bypass read of x3 during its write
      set_idle();
      we0 = 1; wr0_addr = 5'd3; wr0_data = 32'h42;
      rs_addr[AW +: AW] = 5'd3;
      #1;
      check_val("x3_bypass", rs_data[DW +: DW], 32'h42);
      check_val("x3_nobypass", rs_data_nb[DW +: DW], 32'h0);
      run_cycle();

      // Scoreboard lifecycle on x9
      set_idle();
      issue = 1; issue_addr = 5'd9;
      run_cycle();
      set_idle();
      rs_addr[4:0] = 5'd9;
      #1;
      check_val("x9_busy_vec", {31'b0, busy_vec[9]}, 32'h1);
      check_val("x9_rs_busy", {31'b0, rs_busy[0]}, 32'h1);
      run_cycle();
      run_cycle();
      we1 = 1; wr1_addr = 5'd9; wr1_data = 32'h77;
      #1;
      check_val("x9_wb_busy", {31'b0, rs_busy[0]}, 32'h0);
      check_val("x9_wb_data", rs_data[31:0], 32'h77);
      run_cycle();
      check_val("x9_cleared", {31'b0, busy_vec[9]}, 32'h0);

      // Set beats clear on x4
      set_idle();
      issue = 1; issue_addr = 5'd4;
      run_cycle();
      issue = 1; issue_addr = 5'd4;
      we0 = 1; wr0_addr = 5'd4; wr0_data = 32'h99;
      #1;
      check_val("x4_waw", {31'b0, issue_waw}, 32'h1);
      run_cycle();
      check_val("x4_still_busy", {31'b0, busy_vec[4]}, 32'h1);

      // Randomised traffic
      random_cycles(400);

      // Asynchronous reset in the middle of operation
      set_idle();
      we0 = 1; wr0_addr = 5'd5; wr0_data = 32'h1234;
      issue = 1; issue_addr = 5'd6;
      run_cycle();
      set_idle();
      rs_addr[4:0] = 5'd5;
      run_cycle();
      check_val("x5_written", rs_data[31:0], 32'h1234);
      #2;
      rst_n = 1'b0;
      we1 = 1; wr1_addr = 5'd5; wr1_data = 32'hCAFE;
      issue = 1; issue_addr = 5'd6;
      #1;
      model_reset();
      check_val("async_x5", rs_data[31:0], 32'h0);
      check_val("async_busy_vec", busy_vec, 32'h0);
      check_val("async_rs_busy", {30'b0, rs_busy}, 32'h0);
      check_val("async_waw", {31'b0, issue_waw}, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      check_val("rst_hold_busy", busy_vec, 32'h0);
      @(negedge clk);
      set_idle();
      rst_n = 1'b1;
      rs_addr[4:0] = 5'd5;
      run_cycle();
      random_cycles(150);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
